// File: rtl/reg_mem.sv
// reg_mem: 2**ADDR_BITS x DATA_WIDTH register-file memory, one write port, one read port sharing addr.
// Build option REG_MEM_SYNC_READ_EN registers data_out (read-first, one-cycle latency); default read is combinational.
module reg_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 5
) (
   input  logic [ADDR_BITS-1:0]  addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wen,
   input  logic                  clk,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  rst
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      // NOTE: mem_d starts as a copy of mem_q so every path assigns it; otherwise a latch is inferred.
      mem_d = mem_q;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
         end
      end else if (wen) begin
         mem_d[addr] = data_in;
      end
   end

   // NOTE: the array is deliberately reset, so it maps to flops rather than a RAM macro; every word must read 0 after rst.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every reader of mem_q in this edge sees the pre-edge contents.
      mem_q <= mem_d;
   end

`ifdef REG_MEM_SYNC_READ_EN
   logic [DATA_WIDTH-1:0] data_out_q;
   logic [DATA_WIDTH-1:0] data_out_d;

   // Sampling mem_q (not mem_d) gives read-first behaviour on a same-address write.
   always_comb begin
      data_out_d = rst ? '0 : mem_q[addr];
   end

   always_ff @(posedge clk) begin
      data_out_q <= data_out_d;
   end

   assign data_out = data_out_q;
`else
   assign data_out = mem_q[addr];
`endif

endmodule

// File: tb/tb_reg_mem.sv
// Directed self-checking bench for reg_mem; follows REG_MEM_SYNC_READ_EN when it is defined.
module tb_reg_mem;

   logic [4:0] addr;
   logic [7:0] data_in;
   logic       wen;
   logic       clk;
   logic [7:0] data_out;
   logic       rst;

   int compared   = 0;
   int mismatched = 0;

   reg_mem #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
      .addr     (addr),
      .data_in  (data_in),
      .wen      (wen),
      .clk      (clk),
      .data_out (data_out),
      .rst      (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs change #1 after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] exp);
      compared++;
      assert (data_out === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, data_out, exp);
      end
   endtask

   // Read one address with wen=0, honouring the read latency of the build.
   task automatic read_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
      addr = a;
      wen  = 1'b0;
`ifdef REG_MEM_SYNC_READ_EN
      step();
`else
      #2;
`endif
      check($sformatf("%s[%0d]", tag, a), exp);
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      addr    = a;
      data_in = d;
      wen     = 1'b1;
      step();
      wen     = 1'b0;
   endtask

   function automatic logic [7:0] wrap_exp(input int a);
      if (a == 12) return 8'd42;
      else if (a >= 13) return 8'(a - 2);
      else return 8'(a + 30);
   endfunction

   initial begin
      addr    = '0;
      data_in = '0;
      wen     = 1'b0;
      rst     = 1'b1;

      // 1. reset clear
      step();
      rst = 1'b0;
      for (int a = 0; a < 32; a++) read_chk("reset_clear", 5'(a), 8'h00);

      // 2. write with address wrap; i=42 lands on addr 12 and overwrites i=10
      for (int i = 10; i <= 42; i++) wr(5'((i + 2) % 32), 8'(i));
      for (int a = 0; a < 32; a++) read_chk("wrap", 5'(a), wrap_exp(a));

      // 3. hold: addr 5 was last written by i=35
      addr    = 5'd5;
      data_in = 8'hFF;
      wen     = 1'b0;
      repeat (10) step();
      read_chk("hold", 5'd5, 8'h23);

      // 4. read during write at addr 7
      wr(5'd7, 8'h12);
      read_chk("rdw_pre", 5'd7, 8'h12);
      addr    = 5'd7;
      data_in = 8'hA5;
      wen     = 1'b1;
`ifdef REG_MEM_SYNC_READ_EN
      step();
      wen = 1'b0;
      check("rdw_first_edge", 8'h12);
      step();
      check("rdw_second_edge", 8'hA5);
`else
      #2;
      check("rdw_before_edge", 8'h12);
      step();
      wen = 1'b0;
      check("rdw_after_edge", 8'hA5);
`endif

      // 5. reset beats a write on the same edge
      rst     = 1'b1;
      wen     = 1'b1;
      addr    = 5'd3;
      data_in = 8'h5A;
      step();
      rst = 1'b0;
      wen = 1'b0;
      check("rst_prio_edge", 8'h00);
      for (int a = 0; a < 32; a++) read_chk("rst_prio", 5'(a), 8'h00);

      // 6. boundary addresses
      wr(5'd0, 8'h01);
      wr(5'd31, 8'h80);
      read_chk("bound", 5'd0, 8'h01);
      read_chk("bound", 5'd31, 8'h80);
      read_chk("bound_nbr", 5'd1, 8'h00);
      read_chk("bound_nbr", 5'd30, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
